// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: state encoding, store geometry and
// instruction-pointer bounds.
package program_sequencer_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned WORD_W     = 3;
  localparam int unsigned IP_W       = 4;

  localparam logic [IP_W-1:0] LAST_IP = 4'd14;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoaded,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Load handshake, run control and fetch-side outputs of the program sequencer.
// The master side is the controller and execute stage; the slave side is the sequencer.
interface program_sequencer_if #(
  parameter int unsigned PROG_DEPTH = program_sequencer_pkg::PROG_DEPTH,
  parameter int unsigned WORD_W     = program_sequencer_pkg::WORD_W
) ();
  import program_sequencer_pkg::*;

  logic                         load_start;
  logic                         load_valid;
  logic [WORD_W-1:0]            load_data;
  logic                         load_ready;
  logic                         start;
  logic                         stall;
  logic                         jump_en;
  logic [WORD_W-1:0]            jump_target;
  logic [IP_W-1:0]              instr_ptr;
  logic                         halt;
  logic                         flush;
  logic [PROG_DEPTH*WORD_W-1:0] prog_flat;
  logic                         done;
  logic                         err;

  modport master (
    output load_start, load_valid, load_data, start, stall, jump_en, jump_target,
    input  load_ready, instr_ptr, halt, flush, prog_flat, done, err
  );

  modport slave (
    input  load_start, load_valid, load_data, start, stall, jump_en, jump_target,
    output load_ready, instr_ptr, halt, flush, prog_flat, done, err
  );

endinterface

// File: rtl/prog_regfile.sv
// Program store: one synchronous write port and a flattened read port exposing every word.
// Asynchronous reset clears all words.
module prog_regfile #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 3,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AddrW-1:0]       addr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [DEPTH*WIDTH-1:0] rdata_flat
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_flat
    assign rdata_flat[i*WIDTH +: WIDTH] = mem_q[i];
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: loads a program into the store, then steps the fetch pointer by two per
// unstalled cycle, taking even jumps and trapping misaligned ones.
module program_sequencer #(
  parameter int unsigned PROG_DEPTH = program_sequencer_pkg::PROG_DEPTH,
  parameter int unsigned WORD_W     = program_sequencer_pkg::WORD_W
) (
  input logic                clk,
  input logic                rst_n,
  program_sequencer_if.slave bus
);
  import program_sequencer_pkg::*;

  localparam int unsigned CntW = $clog2(PROG_DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(PROG_DEPTH - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IP_W-1:0] ip_q;
  logic            flush_q;
  logic            err_q;
  logic            wr_en;

  // A reload request aborts the cycle, so a word presented alongside it is dropped.
  assign wr_en = (state_q == StLoad) && bus.load_valid && !bus.load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ip_q    <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (bus.load_start) begin
        state_q <= StLoad;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (wr_en) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q == LastCnt) state_q <= StLoaded;
            end
          end
          StLoaded: begin
            if (bus.start) begin
              state_q <= StRun;
              ip_q    <= '0;
            end
          end
          StRun: begin
            // Stall wins: execute keeps jump_en high until the first unstalled cycle.
            if (!bus.stall) begin
              if (bus.jump_en) begin
                if (bus.jump_target[0]) begin
                  state_q <= StDone;
                  err_q   <= 1'b1;
                end else begin
                  ip_q    <= IP_W'(bus.jump_target);
                  flush_q <= 1'b1;
                end
              end else if (ip_q == LAST_IP) begin
                state_q <= StDone;
              end else begin
                ip_q <= ip_q + IP_W'(2);
              end
            end
          end
          StDone: begin
            if (bus.start) begin
              state_q <= StRun;
              ip_q    <= '0;
              err_q   <= 1'b0;
            end
          end
          // Idle leaves only through load_start; illegal encodings recover to idle.
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.load_ready = (state_q == StLoad);
  assign bus.done       = (state_q == StDone);
  assign bus.halt       = (state_q != StRun) || bus.stall;
  assign bus.instr_ptr  = ip_q;
  assign bus.flush      = flush_q;
  assign bus.err        = err_q;

  prog_regfile #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (WORD_W)
  ) u_prog_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_en),
    .addr       (cnt_q),
    .wdata      (bus.load_data),
    .rdata_flat (bus.prog_flat)
  );

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: per-cycle expectations are queued as stimulus is
// driven and compared against the outputs sampled just after the following clock edge.
module tb_program_sequencer;

  logic clk;
  logic rst_n;

  program_sequencer_if bus ();

  program_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] ip;
    logic       halt;
    logic       flush;
    logic       done;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [2:0] prog_p [16] = '{3'd2, 3'd4, 3'd1, 3'd1, 3'd7, 3'd5, 3'd4, 3'd0,
                              3'd0, 3'd3, 3'd1, 3'd5, 3'd6, 3'd0, 3'd3, 3'd5};
  logic [2:0] prog_r [16];

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack(input logic [2:0] w [16]);
    logic [47:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*3 +: 3] = w[i];
    return f;
  endfunction

  // Queue what the outputs must be after the next edge, then take the edge and compare.
  task automatic tick(input string tag, input logic [3:0] ip, input logic halt,
                      input logic flush, input logic done, input logic err, input logic rdy);
    exp_t e;
    e.tag = tag; e.ip = ip; e.halt = halt; e.flush = flush;
    e.done = done; e.err = err; e.rdy = rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".ip"},    48'(bus.instr_ptr),  48'(e.ip));
    check_eq({e.tag, ".halt"},  48'(bus.halt),       48'(e.halt));
    check_eq({e.tag, ".flush"}, 48'(bus.flush),      48'(e.flush));
    check_eq({e.tag, ".done"},  48'(bus.done),       48'(e.done));
    check_eq({e.tag, ".err"},   48'(bus.err),        48'(e.err));
    check_eq({e.tag, ".rdy"},   48'(bus.load_ready), 48'(e.rdy));
  endtask

  task automatic load_words(input logic [2:0] w [16], input logic [3:0] ip, input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = w[i];
      tick($sformatf("%s[%0d]", tag, i), ip, 1'b1, 1'b0, 1'b0, 1'b0, (i < 15));
      if (i == 0) check_eq({tag, ".word0_next"}, 48'(bus.prog_flat[2:0]), 48'(w[0]));
    end
    bus.load_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog_r[i] = 3'((i * 5 + 3) % 8);
    rst_n           = 1'b0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.start       = 1'b0;
    bus.stall       = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_target = '0;
    #3;
    check_eq("rst.ip",    48'(bus.instr_ptr),  48'd0);
    check_eq("rst.halt",  48'(bus.halt),       48'd1);
    check_eq("rst.flush", 48'(bus.flush),      48'd0);
    check_eq("rst.done",  48'(bus.done),       48'd0);
    check_eq("rst.err",   48'(bus.err),        48'd0);
    check_eq("rst.rdy",   48'(bus.load_ready), 48'd0);
    check_eq("rst.prog",  bus.prog_flat,       48'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle ignores start and stray load data.
    bus.start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 3'd5;
    tick("idle_start", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0; bus.load_valid = 1'b0;
    check_eq("idle.prog", bus.prog_flat, 48'd0);

    bus.load_start = 1'b1;
    tick("load_go", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.load_start = 1'b0;
    load_words(prog_p, 4'd0, "load_p");
    check_eq("prog_p.flat",  bus.prog_flat,         pack(prog_p));
    check_eq("prog_p.word0", 48'(bus.prog_flat[2:0]),   48'd2);
    check_eq("prog_p.w15",   48'(bus.prog_flat[47:45]), 48'd5);

    bus.load_valid = 1'b1; bus.load_data = 3'd7;
    tick("loaded_valid", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    check_eq("loaded.prog", bus.prog_flat, pack(prog_p));

    // Straight-line run to completion.
    bus.start = 1'b1;
    tick("run0", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) tick("run", 4'(2 * k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("done", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("done_hold", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Jump back to 0 from the last instruction.
    bus.start = 1'b1;
    tick("rerun0", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) tick("rerun", 4'(2 * k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.jump_en = 1'b1; bus.jump_target = 3'd0;
    tick("jmp_at14", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.jump_en = 1'b0;
    tick("after_jmp", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall holds a pending jump at ip 6.
    tick("to4", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("to6", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 3'd2;
    for (int k = 0; k < 3; k++) tick("stall", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    tick("stall_rel", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.jump_en = 1'b0;
    tick("post_stall", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned jump traps; start clears it, load_start clears a second one.
    bus.jump_en = 1'b1; bus.jump_target = 3'd3;
    tick("odd", 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.jump_en = 1'b0;
    tick("odd_hold", 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick("restart", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("restart2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.jump_en = 1'b1; bus.jump_target = 3'd5;
    tick("odd2", 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.jump_en = 1'b0; bus.load_start = 1'b1;
    tick("ls_from_done", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.load_start = 1'b0;

    // Abort a load at word 7, then reload all 16 words.
    for (int i = 0; i < 7; i++) begin
      bus.load_valid = 1'b1; bus.load_data = 3'($urandom_range(0, 7));
      tick("partial", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    bus.load_start = 1'b1;
    tick("abort", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.load_start = 1'b0; bus.load_valid = 1'b0;
    load_words(prog_r, 4'd2, "reload");
    check_eq("prog_r.flat", bus.prog_flat, pack(prog_r));

    // load_start beats start in the same loaded cycle.
    bus.load_start = 1'b1; bus.start = 1'b1;
    tick("ls_and_start", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.load_start = 1'b0; bus.start = 1'b0;
    tick("still_load", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at word 9 discards the partial load.
    for (int i = 0; i < 9; i++) begin
      bus.load_valid = 1'b1; bus.load_data = 3'd6;
      tick("pre_rst", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst.prog", bus.prog_flat,       48'd0);
    check_eq("midrst.rdy",  48'(bus.load_ready), 48'd0);
    check_eq("midrst.ip",   48'(bus.instr_ptr),  48'd0);
    check_eq("midrst.halt", 48'(bus.halt),       48'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick("idle_after_rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0; bus.load_valid = 1'b1; bus.load_data = 3'd7;
    tick("idle_valid", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.load_valid = 1'b0;
    check_eq("idle2.prog", bus.prog_flat, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
